// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver slice.
//   ps2_state_e : deframer FSM state encoding
//   XK_*        : bit positions inside the 16-bit xkey status word
//   FRAME_BITS  : PS/2 frame length (start + 8 data + parity + stop)
//   odd_parity_ok() : 1 when {byte, parity} holds an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned XK_NEMPTY  = 15;
  localparam int unsigned XK_OVF     = 14;
  localparam int unsigned XK_PERR    = 13;
  localparam int unsigned XK_FERR    = 12;
  localparam int unsigned XK_LVL_MSB = 11;
  localparam int unsigned XK_LVL_LSB = 8;
  localparam int unsigned XK_HD_MSB  = 7;
  localparam int unsigned XK_HD_LSB  = 0;

  localparam int unsigned FRAME_BITS = 11;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// sync_fifo: 8-bit circular buffer, depth 2**DEPTH_LOG2, with level counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write strobe and data (ignored when full unless popping)
//   pop        : read strobe (ignored when empty)
//   dout       : registered head entry, 8'h00 when empty
//   level      : registered occupancy 0..depth
//   full/empty : registered status
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [7:0]    dout_q, dout_d;
  logic          pop_eff, push_eff;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pop_eff  = pop & ~empty_q;
  assign push_eff = push & (~full_q | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
    // Head is registered from next-state, bypassing the write when the
    // incoming byte lands on the new read slot.
    if (empty_d)
      dout_d = '0;
    else if (push_eff && (wr_ptr_q == rd_ptr_d))
      dout_d = din;
    else
      dout_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with scan-code FIFO (clk25 domain).
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   ps2_clk  : raw asynchronous PS/2 clock
//   ps2_data : raw asynchronous PS/2 data
//   rd_en    : one-cycle pop strobe
//   err_clr  : one-cycle strobe clearing ovf/perr/ferr
//   xkey     : {nempty, ovf, perr, ferr, level[3:0], head[7:0]}
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 3,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        err_clr,
  output logic [15:0] xkey
);

  localparam int unsigned TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned DATA_BITS = FRAME_BITS - 3;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s, dat_s, clk_prev_q, fall;

  ps2_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        perr_frame_q;
  logic [TO_W-1:0] to_cnt_q;
  logic        push_q;
  logic [7:0]  push_byte_q;
  logic        ovf_q, perr_q, ferr_q;

  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                fifo_full, fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Deframer, timeout and sticky flags. Flag sets are written after the
  // clear so that a coincident set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_frame_q <= 1'b0;
      to_cnt_q     <= '0;
      push_q       <= 1'b0;
      push_byte_q  <= '0;
      ovf_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (err_clr) begin
        ovf_q  <= 1'b0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (push_q && fifo_full && !rd_en) ovf_q <= 1'b1;

      if (state_q == IDLE) begin
        to_cnt_q <= '0;
        if (fall && !dat_s) begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
        end
      end else if (fall) begin
        to_cnt_q <= '0;
        case (state_q)
          DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) state_q <= PARITY;
          end
          PARITY: begin
            perr_frame_q <= ~odd_parity_ok(shift_q, dat_s);
            state_q      <= STOP;
          end
          STOP: begin
            if (!dat_s) begin
              ferr_q <= 1'b1;
            end else if (perr_frame_q) begin
              perr_q <= 1'b1;
            end else begin
              push_q      <= 1'b1;
              push_byte_q <= shift_q;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_q  <= IDLE;
        to_cnt_q <= '0;
        ferr_q   <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push_q),
    .pop   (rd_en),
    .din   (push_byte_q),
    .dout  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full 16-deep FIFO wraps to 4'h0 here; nempty still reads 1.
  assign xkey[XK_NEMPTY]               = ~fifo_empty;
  assign xkey[XK_OVF]                  = ovf_q;
  assign xkey[XK_PERR]                 = perr_q;
  assign xkey[XK_FERR]                 = ferr_q;
  assign xkey[XK_LVL_MSB:XK_LVL_LSB]   = 4'(fifo_level);
  assign xkey[XK_HD_MSB:XK_HD_LSB]     = fifo_head;

endmodule
